// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: I2S (Philips format) transmitter for the DAC path.
// A one-deep valid/ready buffer feeds a last-sample register; the latched
// sample is sent MSB-first in both the left and right slot of each frame.
// bclk and lrclk are derived from clk; an empty buffer at frame start
// pulses underrun and repeats the previous sample.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | stopped, all serial outputs held low, counters cleared
//   ST_RUN   | bclk running, a new sample is loaded at every k=0
//   ST_DRAIN | stop requested; finish the frame, then fall back to IDLE
module i2s_sample_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int KW = $clog2(FRAME_BITS);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(FRAME_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;
  logic [SAMPLE_WIDTH-1:0] last_q, last_d;
  logic [SAMPLE_WIDTH-1:0] buf_q, buf_d;
  logic                    empty_q, empty_d;

  logic                    active;
  logic                    div_tc;
  logic                    bclk_fall;
  logic                    k_wrap;
  logic                    stop_now;
  logic                    load_now;
  logic                    xfer;
  logic [KW-1:0]           k_inc;
  logic [SAMPLE_WIDTH-1:0] sample_nxt;
  logic                    lr_nxt;
  logic                    bit_nxt;

  assign active     = (state_q != ST_IDLE);
  assign div_tc     = (div_q == DIV_LAST);
  assign bclk_fall  = active && div_tc && bclk_q;
  assign k_wrap     = bclk_fall && (k_q == K_LAST);
  // A draining transmitter stops exactly where the next frame would begin.
  assign stop_now   = k_wrap && (state_q == ST_DRAIN) && !enable;
  assign load_now   = k_wrap && !stop_now;
  assign k_inc      = (k_q == K_LAST) ? '0 : k_q + KW'(1);
  assign xfer       = din_valid && empty_q;
  // The load looks at the buffer as it was before this edge.
  assign sample_nxt = (load_now && !empty_q) ? buf_q : last_q;

  // Decode word select and data bit for the frame position being entered.
  always_comb begin
    int kk;
    int pos;
    kk      = int'(k_inc);
    pos     = (kk < SLOT_WIDTH) ? kk : kk - SLOT_WIDTH;
    lr_nxt  = (kk >= SLOT_WIDTH - 1) && (kk <= 2 * SLOT_WIDTH - 2);
    bit_nxt = 1'b0;
    if (pos < SAMPLE_WIDTH) begin
      bit_nxt = sample_nxt[IW'(SAMPLE_WIDTH - 1 - pos)];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (stop_now)    state_d = ST_IDLE;
        else if (enable) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: divider, frame pointer, serial pins and sample load.
  always_comb begin
    div_d      = div_q;
    k_d        = k_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    last_d     = last_q;
    if (!active) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      // Park one position before the frame so the first fall enters k=0.
      k_d     = enable ? K_LAST : '0;
    end else begin
      div_d = div_tc ? '0 : div_q + DW'(1);
      if (div_tc) bclk_d = !bclk_q;
      if (stop_now) begin
        div_d   = '0;
        k_d     = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
      end else if (bclk_fall) begin
        k_d     = k_inc;
        lrclk_d = lr_nxt;
        sdata_d = bit_nxt;
      end
      if (load_now) begin
        last_d     = sample_nxt;
        underrun_d = empty_q;
      end
    end
  end

  // Input buffer: filled by a handshake, emptied by a frame-start load.
  always_comb begin
    buf_d   = buf_q;
    empty_d = empty_q;
    if (load_now && !empty_q) begin
      empty_d = 1'b1;
    end else if (xfer) begin
      buf_d   = din;
      empty_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      k_q        <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      last_q     <= '0;
      buf_q      <= '0;
      empty_q    <= 1'b1;
    end else begin
      div_q      <= div_d;
      k_q        <= k_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      last_q     <= last_d;
      buf_q      <= buf_d;
      empty_q    <= empty_d;
    end
  end

  assign din_ready = empty_q;
  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Testbench for i2s_sample_tx: frame-level vector table, hand-written
// stop/restart/reset sequences, a randomized run against a cycle model
// derived from the frame timing rules, and a minimum-divider instance.
module tb_i2s_sample_tx;
  localparam int D  = 4;
  localparam int S  = 32;
  localparam int W  = 16;
  localparam int F  = 2 * S * 2 * D;
  localparam int D2 = 1;
  localparam int S2 = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic en, dv, dr, bk, lr, sd, ur;
  logic [15:0] din;
  logic en2, dv2, dr2, bk2, lr2, sd2, ur2;
  logic [15:0] din2;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int c0     = 0;

  logic [1:0]  cap0[$];
  logic [1:0]  cap1[$];
  int          urf0[$];
  int          urf1[$];
  logic [15:0] feedq[$];
  logic [15:0] feedq2[$];
  bit          rnd_mode = 1'b0;
  bit          mdl_on   = 1'b0;

  int          m_c;
  bit          m_full;
  logic [15:0] m_buf, m_last;

  typedef struct {
    logic [15:0] smp;
    int          ur;
  } frame_vec_t;
  frame_vec_t tbl[6];

  always #5 clk = ~clk;

  i2s_sample_tx #(.SAMPLE_WIDTH(W), .SLOT_WIDTH(S), .BCLK_DIV(D)) dut (
    .clk(clk), .reset(rst_n), .enable(en), .din(din), .din_valid(dv),
    .din_ready(dr), .bclk(bk), .lrclk(lr), .sdata(sd), .underrun(ur)
  );

  i2s_sample_tx #(.SAMPLE_WIDTH(W), .SLOT_WIDTH(S2), .BCLK_DIV(D2)) dut_min (
    .clk(clk), .reset(rst_n), .enable(en2), .din(din2), .din_valid(dv2),
    .din_ready(dr2), .bclk(bk2), .lrclk(lr2), .sdata(sd2), .underrun(ur2)
  );

  // Receiver view: the DAC samples lrclk/sdata on bclk rising edges.
  always @(posedge bk)  cap0.push_back({lr, sd});
  always @(posedge bk2) cap1.push_back({lr2, sd2});

  // Record which frame each underrun pulse belongs to.
  always @(negedge clk) begin
    if (ur)  urf0.push_back((cap0.size() - 1) / (2 * S));
    if (ur2) urf1.push_back((cap1.size() - 1) / (2 * S2));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] o0();
    return 64'({bk, lr, sd, ur, dr});
  endfunction

  function automatic logic [63:0] o1();
    return 64'({bk2, lr2, sd2, ur2, dr2});
  endfunction

  function automatic int cnow();
    return cyc - c0 - 1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Expected frame as seen by the receiver, bit j = frame position k=j.
  function automatic logic [63:0] exp_bits(logic [15:0] smp, int slot, bit want_lr);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 2 * slot; j++) begin
      int pos;
      pos = (j < slot) ? j : j - slot;
      if (want_lr) r[j] = (j >= slot - 1) && (j <= 2 * slot - 2);
      else if (pos < W) r[j] = smp[W - 1 - pos];
    end
    return r;
  endfunction

  // Captured frame n; index 0 of the capture is the rise before k=0.
  function automatic logic [63:0] cap_bits(bit which, int n, int slot, bit want_lr);
    logic [63:0] r;
    logic [1:0]  e;
    r = '0;
    for (int j = 0; j < 2 * slot; j++) begin
      int idx;
      idx = 1 + n * 2 * slot + j;
      e = 2'bxx;
      if (!which && idx < cap0.size()) e = cap0[idx];
      if (which && idx < cap1.size())  e = cap1[idx];
      r[j] = want_lr ? e[1] : e[0];
    end
    return r;
  endfunction

  function automatic int ur_in(bit which, int n);
    int c;
    c = 0;
    if (!which) begin
      foreach (urf0[i]) if (urf0[i] == n) c++;
    end else begin
      foreach (urf1[i]) if (urf1[i] == n) c++;
    end
    return c;
  endfunction

  // Reference: cycle c after the enabling edge; frames start at 2D + nF.
  task automatic model_step();
    logic pre, ure, eb, el, es;
    int   t, k, pos;
    m_c++;
    pre = m_full;
    ure = 1'b0;
    if (m_c >= 2 * D && (m_c - 2 * D) % F == 0) begin
      if (pre) begin
        m_last = m_buf;
        m_full = 1'b0;
      end else begin
        ure = 1'b1;
      end
    end
    if (dv && !pre) begin
      m_buf  = din;
      m_full = 1'b1;
    end
    eb = ((m_c / D) % 2) == 1;
    el = 1'b0;
    es = 1'b0;
    if (m_c >= 2 * D) begin
      t   = m_c - 2 * D;
      k   = (t / (2 * D)) % (2 * S);
      pos = (k < S) ? k : k - S;
      el  = (k >= S - 1) && (k <= 2 * S - 2);
      if (pos < W) es = m_last[W - 1 - pos];
    end
    chk($sformatf("model_c%0d", m_c), o0(), 64'({eb, el, es, ure, !m_full}));
  endtask

  // One clock: observe at the falling edge, then drive the next inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mdl_on) model_step();
    if (rnd_mode) begin
      dv  = ($urandom_range(0, 299) == 0);
      din = 16'($urandom);
    end else if (feedq.size() > 0) begin
      dv  = 1'b1;
      din = feedq[0];
      if (dr) void'(feedq.pop_front());
    end else begin
      dv = 1'b0;
    end
    if (feedq2.size() > 0) begin
      dv2  = 1'b1;
      din2 = feedq2[0];
      if (dr2) void'(feedq2.pop_front());
    end else begin
      dv2 = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    en2      = 1'b0;
    mdl_on   = 1'b0;
    rnd_mode = 1'b0;
    feedq.delete();
    feedq2.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cap0.delete();
    cap1.delete();
    urf0.delete();
    urf1.delete();
  endtask

  initial begin
    int bad;
    int b;
    logic [15:0] v;

    rst_n = 1'b0;
    en = 1'b0; dv = 1'b0; din = '0;
    en2 = 1'b0; dv2 = 1'b0; din2 = '0;

    tbl[0] = '{16'hc000, 0};
    tbl[1] = '{16'hc000, 1};
    tbl[2] = '{16'h0001, 0};
    tbl[3] = '{16'h0002, 0};
    tbl[4] = '{16'h0003, 0};
    tbl[5] = '{16'h0003, 1};

    repeat (3) tick();
    chk("reset_state", o0(), 64'h1);
    chk("reset_state_min", o1(), 64'h1);
    rst_n = 1'b1;
    tick();

    // Single sample, underrun, back-pressure: frame-level vector table.
    do_reset();
    feedq.push_back(16'hc000);
    en = 1'b1;
    c0 = cyc;
    while (cnow() < 600) tick();
    feedq.push_back(16'h0001);
    feedq.push_back(16'h0002);
    feedq.push_back(16'h0003);
    b = 0;
    while (feedq.size() > 2 && b < 20) begin
      tick();
      b++;
    end
    chk("bp_first_accept", 64'(feedq.size()), 64'd2);
    tick();
    chk("bp_ready_drop", 64'(dr), 64'h0);
    while (cnow() < 2 * D + 6 * F + 2 * D) tick();
    chk("tbl_capture_len", 64'(cap0.size() >= 1 + 6 * 2 * S), 64'h1);
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("tbl%0d_sdata", n), cap_bits(0, n, S, 1'b0), exp_bits(tbl[n].smp, S, 1'b0));
      chk($sformatf("tbl%0d_lrclk", n), cap_bits(0, n, S, 1'b1), exp_bits(tbl[n].smp, S, 1'b1));
      chk($sformatf("tbl%0d_underrun", n), 64'(ur_in(0, n)), 64'(tbl[n].ur));
    end

    // Stop at k=5: the frame drains through k=63, then IDLE.
    do_reset();
    feedq.push_back(16'h1234);
    en = 1'b1;
    c0 = cyc;
    while (cnow() < 2 * D + 5 * 2 * D) tick();
    en = 1'b0;
    while (cnow() < 2 * D + F - 1) tick();
    chk("drain_k63", 64'({bk, lr, sd}), 64'h4);
    tick();
    chk("drain_idle", 64'({bk, lr, sd, ur}), 64'h0);
    repeat (300) tick();
    chk("drain_rise_count", 64'(cap0.size()), 64'd65);
    chk("drain_sdata", cap_bits(0, 0, S, 1'b0), exp_bits(16'h1234, S, 1'b0));
    chk("drain_no_underrun", 64'(urf0.size()), 64'd0);
    chk("drain_ready", 64'(dr), 64'h1);

    // Stop then re-enable during DRAIN: frames continue without a gap.
    do_reset();
    feedq.push_back(16'h5678);
    en = 1'b1;
    c0 = cyc;
    while (cnow() < 2 * D + 5 * 2 * D) tick();
    en = 1'b0;
    while (cnow() < 300) tick();
    en = 1'b1;
    while (cnow() < 1040) tick();
    chk("restart_rise_count", 64'(cap0.size()), 64'd130);
    chk("restart_f0_sdata", cap_bits(0, 0, S, 1'b0), exp_bits(16'h5678, S, 1'b0));
    chk("restart_f1_sdata", cap_bits(0, 1, S, 1'b0), exp_bits(16'h5678, S, 1'b0));
    chk("restart_f0_underrun", 64'(ur_in(0, 0)), 64'd0);
    chk("restart_f1_underrun", 64'(ur_in(0, 1)), 64'd1);

    // Asynchronous reset during the right slot.
    do_reset();
    feedq.push_back(16'hc0de);
    feedq.push_back(16'h1111);
    en = 1'b1;
    c0 = cyc;
    while (cnow() < 2 * D + 40 * 2 * D) tick();
    chk("rst_pre_state", 64'({lr, dr}), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", o0(), 64'h1);
    en = 1'b0;
    feedq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (bk || lr || sd || ur) bad++;
    end
    chk("rst_quiet", 64'(bad), 64'd0);
    chk("rst_ready", 64'(dr), 64'h1);

    // Randomized traffic against the reference model.
    do_reset();
    m_c    = -1;
    m_full = 1'b0;
    m_buf  = '0;
    m_last = '0;
    en       = 1'b1;
    rnd_mode = 1'b1;
    mdl_on   = 1'b1;
    repeat (2 * D + 8 * F) tick();
    mdl_on   = 1'b0;
    rnd_mode = 1'b0;
    en       = 1'b0;

    // Minimum divider, 16-bit slots: bclk = clk/2, no padding.
    do_reset();
    feedq2.push_back(16'h8001);
    feedq2.push_back(16'h7ffe);
    en2 = 1'b1;
    c0  = cyc;
    for (int i = 0; i < 16; i++) begin
      tick();
      v[i] = bk2;
    end
    chk("min_bclk_div2", 64'(v), 64'haaaa);
    while (cnow() < 2 * D2 + 2 * 2 * S2 * 2 * D2 + 2) tick();
    chk("min_f0_sdata", cap_bits(1, 0, S2, 1'b0), exp_bits(16'h8001, S2, 1'b0));
    chk("min_f0_lrclk", cap_bits(1, 0, S2, 1'b1), exp_bits(16'h8001, S2, 1'b1));
    chk("min_f1_sdata", cap_bits(1, 1, S2, 1'b0), exp_bits(16'h7ffe, S2, 1'b0));
    chk("min_f1_lrclk", cap_bits(1, 1, S2, 1'b1), exp_bits(16'h7ffe, S2, 1'b1));
    chk("min_underrun", 64'(ur_in(1, 0) + ur_in(1, 1)), 64'd0);
    en2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/i2s_sample_tx.md
# i2s_sample_tx

Serializer that sits downstream of the biquad filter chain and drives the external audio DAC over I2S (Philips format). It accepts signed two's-complement samples from the filter output over a one-deep valid/ready buffer. It sends each sample on both left and right slots of one frame. It generates `bclk` and `lrclk` from the system clock and flags underruns when no sample is ready at a frame boundary.

## Interface
- `SAMPLE_WIDTH`, 16: width of `din`, transmitted MSB-first.
- `SLOT_WIDTH`, 32: bclk periods per channel slot. Must be ≥ `SAMPLE_WIDTH`.
- `BCLK_DIV`, 4: system clocks per half bclk period. Must be ≥ 1.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run/stop request.
- `din` in SAMPLE_WIDTH: sample, two's complement, sent unmodified.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: buffer empty. A transfer occurs when `din_valid & din_ready` at the clk edge.
- `bclk` out 1: I2S bit clock.
- `lrclk` out 1: word select; 0 = left, 1 = right.
- `sdata` out 1: serial data, changes on bclk falling edges.
- `underrun` out 1: one-cycle pulse, no buffered sample at frame start.

## Operation
- **Reset state:** `reset`=0 asynchronously forces the following; reset applies mid-frame with no completion.
  - State IDLE.
  - `bclk`, `lrclk`, `sdata` and `underrun` = 0; `din_ready` = 1.
  - Buffer empty; last-sample register = 0; counters 0.
- **FSM: IDLE, RUN, DRAIN.**
  - IDLE, `enable`=1: go to RUN. The frame pointer k is set to 2·SLOT_WIDTH−1, with `bclk`=0, `lrclk`=0, `sdata`=0.
  - RUN, `enable`=0: go to DRAIN.
  - DRAIN, `enable`=1: back to RUN with no gap.
  - DRAIN, `enable`=0: at the bclk fall that would enter k=0, go to IDLE instead. No load, no underrun. Outputs are held at 0.
- **Bit clock:** in RUN/DRAIN a divider counts 0..BCLK_DIV−1 and toggles `bclk` at terminal count. In IDLE, `bclk` is held at 0.
- **Frame pointer:** k advances mod 2·SLOT_WIDTH on each bclk falling toggle. Let S = SLOT_WIDTH and W = SAMPLE_WIDTH.
- **Word select:** `lrclk` = 1 for k in [S−1, 2S−2], otherwise 0. It therefore changes one bit before each MSB.
- **Data:**
  - k in [0, W−1]: `sdata` = sample[W−1−k].
  - k in [S, S+W−1]: `sdata` = sample[W−1−(k−S)].
  - All other k: `sdata` = 0 (padding).
- **Sample load at k=0:**
  - Buffer full: load it into the shift/last-sample register and mark the buffer empty.
  - Buffer empty: pulse `underrun` and resend the last sample (0 after reset).
  - The right slot uses the same latched sample as the left slot.
- **Buffer handshake:**
  - `din_ready` is registered and equals "buffer empty".
  - A transfer in the same cycle as a k=0 load fills the buffer for the next frame. The load uses the pre-edge buffer state, so that load counts as an underrun.
  - The buffer is never overwritten.

## Timing
- **Start-up:** the first bclk rise is BCLK_DIV clocks after entering RUN. The first fall (k=0, MSB out) is 2·BCLK_DIV clocks after entering RUN.
- **Periods:** bit period = 2·BCLK_DIV clocks; frame = 2·S·2·BCLK_DIV clocks (512 at defaults).
- **Output edge alignment:**
  - `sdata` and `lrclk` are registered and update on the same clk edge as the bclk 1→0 toggle.
  - They are stable across the bclk rise.
- **Pulse and ready timing:**
  - `underrun` is high for exactly the one clk cycle following the k=0 edge.
  - `din_ready` falls on the edge after a transfer and rises on the edge of the k=0 load.
- **Throughput:** one sample per frame.
- **Latency:** sample in buffer → MSB on `sdata` at the next k=0.

## Test plan
- **Reset mid-frame:** drop `reset` during right slot at defaults → in the same cycle `bclk`/`lrclk`/`sdata`/`underrun` = 0 and `din_ready` = 1. After release, outputs stay 0 while `enable`=0.
- **Single sample:** with `enable`=1, send `din`=16'hc000 before the first fall.
  - Left slot: `lrclk`=0, bits 1,1 then 14 zeros, then 16 zero padding bits.
  - Right slot: identical with `lrclk`=1; `lrclk` rises at k=31.
  - `underrun` stays 0.
- **Underrun:** no second sample → `underrun` pulses 1 cycle at frame-2 k=0 and 16'hc000 repeats in both slots.
- **Back-pressure:** hold `din_valid`=1 with 0x0001, 0x0002, 0x0003.
  - `din_ready` drops after the first transfer.
  - One sample is accepted per frame, transmitted in order, with no underrun.
- **Stop/restart:** deassert `enable` at k=5.
  - The frame completes through k=63, then IDLE with `bclk`=0.
  - Reassert during DRAIN instead → frames continue with no gap.
- **Minimum divider:** `BCLK_DIV`=1, `SLOT_WIDTH`=16 → `bclk` = clk/2 and 32-bit frames with no padding. Samples 16'h8001 and 16'h7ffe are sent back-to-back correctly.
